// File: rtl/iter_sequencer.sv
// Programmable iteration sequencer with early-warning tap flags.
// Counts len ce-qualified iterations; taps fire at set distances before the last.
module iter_sequencer #(
  parameter int MAX_K = 1027,
  parameter int NTAP  = 3,
  localparam int W    = $clog2(MAX_K + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              restart,
  input  logic              abort,
  input  logic [W-1:0]      len,
  input  logic [NTAP*W-1:0] tap_off,
  input  logic              auto_reload,
  output logic              active,
  output logic [W-1:0]      cnt,
  output logic              last,
  output logic              done,
  output logic [NTAP-1:0]   tap,
  output logic              cfg_err
);

  localparam logic [W-1:0] KMAX = W'(MAX_K);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0]            len_q;
  logic [NTAP-1:0][W-1:0]  off_q;
  logic                    reload_q;

  logic [W-1:0]            n_cnt;
  logic                    n_active;
  logic [W-1:0]            n_len;
  logic [NTAP-1:0][W-1:0]  n_off;
  logic                    n_reload;
  logic                    n_done;
  logic                    n_err;
  logic                    n_last;
  logic [NTAP-1:0]         n_tap;
  logic                    fin;

  assign fin = active && (cnt == len_q - ONE);

  always_comb begin
    n_cnt    = cnt;
    n_active = active;
    n_len    = len_q;
    n_off    = off_q;
    n_reload = reload_q;
    n_done   = 1'b0;
    n_err    = 1'b0;
    if (abort) begin
      n_active = 1'b0;
      n_cnt    = '0;
    end else if (restart && (len != '0)) begin
      n_err    = (len > KMAX);
      n_len    = (len > KMAX) ? KMAX : len;
      n_off    = tap_off;
      n_reload = auto_reload;
      n_cnt    = '0;
      n_active = 1'b1;
    end else begin
      // a zero-length restart is rejected and the run carries on
      n_err = restart;
      if (fin) begin
        n_done = 1'b1;
        if (reload_q) n_cnt = '0;
        else n_active = 1'b0;
      end else if (active) begin
        n_cnt = cnt + ONE;
      end
    end
  end

  // Flags compare against next state so they line up with registered cnt
  always_comb begin
    n_last = n_active && (n_cnt == n_len - ONE);
    n_tap  = '0;
    for (int i = 0; i < NTAP; i++) begin
      n_tap[i] = n_active && (n_off[i] < n_len)
                 && (n_cnt == n_len - ONE - n_off[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      cnt      <= '0;
      len_q    <= '0;
      off_q    <= '0;
      reload_q <= 1'b0;
      last     <= 1'b0;
      done     <= 1'b0;
      tap      <= '0;
      cfg_err  <= 1'b0;
    end else if (ce) begin
      active   <= n_active;
      cnt      <= n_cnt;
      len_q    <= n_len;
      off_q    <= n_off;
      reload_q <= n_reload;
      last     <= n_last;
      done     <= n_done;
      tap      <= n_tap;
      cfg_err  <= n_err;
    end
  end

endmodule

// File: tb/tb_iter_sequencer.sv
// Scoreboard bench for iter_sequencer: directed scenarios plus random traffic
// checked against an integer reference model.
module tb_iter_sequencer;
  localparam int MAX_K = 1027;
  localparam int NTAP  = 3;
  localparam int W     = $clog2(MAX_K + 1);

  logic clk = 1'b0;
  logic rst, ce, restart, abort, auto_reload;
  logic [W-1:0] len;
  logic [NTAP*W-1:0] tap_off;
  logic active, last, done, cfg_err;
  logic [W-1:0] cnt;
  logic [NTAP-1:0] tap;

  iter_sequencer #(.MAX_K(MAX_K), .NTAP(NTAP)) dut (
    .clk(clk), .rst(rst), .ce(ce), .restart(restart), .abort(abort),
    .len(len), .tap_off(tap_off), .auto_reload(auto_reload),
    .active(active), .cnt(cnt), .last(last), .done(done),
    .tap(tap), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit active; int cnt; bit last; bit done;
    bit [NTAP-1:0] tap; bit cfg_err;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  int m_active, m_cnt, m_len, m_reload, m_done, m_cfg;
  int m_off[NTAP];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_cnt = 0; m_len = 0; m_reload = 0;
    m_done = 0; m_cfg = 0;
    foreach (m_off[i]) m_off[i] = 0;
  endtask

  function automatic exp_t model_outs();
    exp_t e;
    e.active  = (m_active != 0);
    e.cnt     = m_cnt;
    e.last    = (m_active != 0) && (m_cnt == m_len - 1);
    e.done    = (m_done != 0);
    e.cfg_err = (m_cfg != 0);
    for (int i = 0; i < NTAP; i++)
      e.tap[i] = (m_active != 0) && (m_cnt == m_len - 1 - m_off[i]);
    return e;
  endfunction

  task automatic model_edge(bit r, bit a, int l, int o0, int o1, int o2, bit ar);
    if (a) begin
      m_active = 0; m_cnt = 0; m_done = 0; m_cfg = 0;
    end else if (r && l > 0) begin
      m_cfg = (l > MAX_K);
      m_len = (l > MAX_K) ? MAX_K : l;
      m_off[0] = o0; m_off[1] = o1; m_off[2] = o2;
      m_reload = ar; m_cnt = 0; m_active = 1; m_done = 0;
    end else begin
      m_cfg = r;
      m_done = 0;
      if (m_active != 0) begin
        if (m_cnt == m_len - 1) begin
          m_done = 1;
          if (m_reload != 0) m_cnt = 0;
          else m_active = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic step(bit c, bit r, bit a, int l, int o0, int o1, int o2, bit ar);
    @(negedge clk);
    ce = c; restart = r; abort = a; auto_reload = ar;
    len = W'(l);
    tap_off = {W'(o2), W'(o1), W'(o0)};
    if (c) model_edge(r, a, l, o0, o1, o2, ar);
    @(posedge clk);
    q.push_back(model_outs());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic go(int l, int o0, int o1, int o2, bit ar);
    step(1, 1, 0, l, o0, o1, o2, ar);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ce = 0; restart = 0; abort = 0;
    #1 rst = 1;
    #1;
    chk("rst_active", active, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_last", last, 0);
    chk("rst_done", done, 0);
    chk("rst_tap", tap, 0);
    chk("rst_cfg_err", cfg_err, 0);
    model_clear();
    #1 rst = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("active", active, e.active);
        chk("cnt", cnt, e.cnt);
        chk("last", last, e.last);
        chk("done", done, e.done);
        chk("tap", tap, e.tap);
        chk("cfg_err", cfg_err, e.cfg_err);
      end
    end
  end

  initial begin
    int l, o0, o1, o2;
    rst = 0; ce = 0; restart = 0; abort = 0;
    auto_reload = 0; len = '0; tap_off = '0;
    model_clear();
    #1 rst = 1;
    #1;
    chk("init_active", active, 0);
    chk("init_cnt", cnt, 0);
    chk("init_done", done, 0);
    chk("init_tap", tap, 0);
    #11 rst = 0;

    go(8, 0, 0, 0, 0); idle(4);
    do_reset(); idle(3);

    go(1027, 1, 2, 4, 0); idle(1030);

    go(5, 0, 1, 2, 0);
    for (int i = 0; i < 14; i++) step(i[0], 0, 0, 0, 0, 0, 0, 0);

    go(3, 1, 9, 9, 1); idle(10);
    step(1, 0, 1, 0, 0, 0, 0, 0); idle(2);

    go(0, 0, 0, 0, 0); idle(2);
    go(6, 0, 1, 2, 0); idle(2); go(0, 0, 0, 0, 0); idle(5);
    go(2000, 0, 1, 2, 0); idle(1030);
    go(1, 0, 1, 2, 0); idle(2);
    go(3, 5, 5, 5, 0); idle(4);
    go(4, 1, 1, 0, 0); idle(3); go(4, 1, 1, 0, 0); idle(5);
    go(5, 0, 0, 0, 0); idle(1);
    step(1, 1, 1, 5, 0, 0, 0, 0); idle(2);
    go(6, 0, 1, 3, 0); idle(2); go(6, 0, 1, 3, 0); idle(7);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        l  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047))
                                         : int'($urandom_range(0, 12));
        o0 = $urandom_range(0, 10);
        o1 = $urandom_range(0, 10);
        o2 = $urandom_range(0, 10);
        step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 79) == 0, l, o0, o1, o2,
             bit'($urandom_range(0, 1)));
      end
    end

    idle(2);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1 chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
